// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch PC sequencer: FSM state codes, next-PC
// select codes, and the opcode/funct values used to recognise j/jal/jr.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        PCS_RUN     = 2'b00,
        PCS_JR_WAIT = 2'b01,
        PCS_HALT    = 2'b10
    } pcs_state_e;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_HOLD = 3'd4
    } npc_sel_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) && (fn == FN_JR);
    endfunction

endpackage

// File: rtl/pc_sequencer_target_mux.sv
// pc_target_mux: combinational choice of the next fetch PC from an NPC_* code.
// The j/jal region nibble is taken from pc_id+4, so only the carry out of
// bits [27:2] matters; the byte offset of pc_id never affects the target.
module pc_target_mux
    import pc_sequencer_pkg::*;
(
    input  npc_sel_e    sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:2] pc_id_i,
    input  logic [25:0] jidx_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] npc_o
);

    logic [3:0] j_region;

    assign j_region = pc_id_i[31:28] + {3'b000, &pc_id_i[27:2]};

    // Select the next PC; all additions wrap modulo 2^32.
    always_comb begin
        npc_o = pc_i + 32'd4;
        case (sel_i)
            NPC_SEQ:  npc_o = pc_i + 32'd4;
            NPC_BR:   npc_o = br_target_i;
            NPC_J:    npc_o = {j_region, jidx_i, 2'b00};
            NPC_JR:   npc_o = rs_data_i;
            NPC_HOLD: npc_o = pc_i;
            default:  npc_o = pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and the PC of the instruction in IF/ID,
// arbitrates EX branch / ID jump / ID jr redirects, load-use holds and halt,
// and drives the IF/ID stall/flush and ID/EX bubble controls.
// Optional feature macro: PC_PERF_CNT_EN (saturating stall/flush counters).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned JR_WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_id,
    input  logic [31:0] rs_data,
    input  logic        rs_ready,
    input  logic        load_use_stall,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_id,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        redirect,
    output logic        err_jr_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [3:0] JR_LAST = 4'(JR_WAIT_MAX - 1);

    pcs_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [3:0]  jr_cnt_q, jr_cnt_d;
    npc_sel_e    npc_sel;
    logic [31:0] npc;
    logic        stall_c, flush_c, bubble_c, redirect_c, err_c;
    logic        id_jump, id_jr;

    assign id_jump = is_jump(ir_id[31:26]);
    assign id_jr   = is_jr(ir_id[31:26], ir_id[5:0]);

    pc_target_mux u_target_mux (
        .sel_i       (npc_sel),
        .pc_i        (pc_q),
        .pc_id_i     (pc_id_q[31:2]),
        .jidx_i      (ir_id[25:0]),
        .rs_data_i   (rs_data),
        .br_target_i (ex_br_target),
        .npc_o       (npc)
    );

    // Priority arbitration: EX branch > HALT > load-use > j/jal > jr > sequential.
    always_comb begin
        state_d    = state_q;
        jr_cnt_d   = jr_cnt_q;
        npc_sel    = NPC_SEQ;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        redirect_c = 1'b0;
        err_c      = 1'b0;

        if (ex_br_taken) begin
            npc_sel    = NPC_BR;
            flush_c    = 1'b1;
            bubble_c   = 1'b1;
            redirect_c = 1'b1;
            state_d    = PCS_RUN;
            jr_cnt_d   = '0;
        end else if (state_q == PCS_HALT) begin
            npc_sel  = NPC_HOLD;
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (resume) begin
                state_d = PCS_RUN;
            end
        end else if (load_use_stall) begin
            // Hold everything, including any jr wait count in progress.
            npc_sel  = NPC_HOLD;
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (id_jump) begin
            npc_sel    = NPC_J;
            flush_c    = 1'b1;
            redirect_c = 1'b1;
            state_d    = PCS_RUN;
            jr_cnt_d   = '0;
        end else if (id_jr && rs_ready) begin
            npc_sel    = NPC_JR;
            flush_c    = 1'b1;
            redirect_c = 1'b1;
            state_d    = PCS_RUN;
            jr_cnt_d   = '0;
        end else if (id_jr) begin
            npc_sel  = NPC_HOLD;
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = PCS_JR_WAIT;
            if (jr_cnt_q == JR_LAST) begin
                err_c    = 1'b1;
                jr_cnt_d = '0;
            end else begin
                jr_cnt_d = jr_cnt_q + 4'd1;
            end
        end else begin
            npc_sel  = NPC_SEQ;
            state_d  = PCS_RUN;
            jr_cnt_d = '0;
        end

        // A halt request is ignored in any cycle that redirects the PC.
        if (halt_req && !redirect_c && (state_q != PCS_HALT)) begin
            state_d  = PCS_HALT;
            jr_cnt_d = '0;
        end

        pc_d = npc;
        case (npc_sel)
            NPC_SEQ:  pc_id_d = pc_q;
            NPC_HOLD: pc_id_d = pc_id_q;
            default:  pc_id_d = npc;
        endcase
    end

    // FSM state, fetch PC, ID-stage PC and jr wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PCS_RUN;
            pc_q     <= RESET_PC;
            pc_id_q  <= RESET_PC;
            jr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_id_q  <= pc_id_d;
            jr_cnt_q <= jr_cnt_d;
        end
    end

    assign pc             = pc_q;
    assign pc_id          = pc_id_q;
    assign if_id_stall    = stall_c & ~rst;
    assign if_id_flush    = flush_c & ~rst;
    assign id_ex_bubble   = bubble_c & ~rst;
    assign redirect       = redirect_c & ~rst;
    assign err_jr_timeout = err_c & ~rst;

`ifdef PC_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters for stalled and flushed cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (if_id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule
